// File: rtl/gcm_input_packer_if.sv
// rtl/gcm_input_packer_if.sv - word input, block/AAD/length output channels of the GCM input packer
interface gcm_input_packer_if;
  logic          iStart;
  logic [0:31]   iWord;
  logic          iWord_valid;
  logic          iWord_type;
  logic          iWord_last;
  logic [2:0]    iWord_bytes;
  logic          oWord_ready;
  logic [0:127]  oAad;
  logic          oAad_valid;
  logic          oAad_last;
  logic          iAad_ready;
  logic [0:127]  oBlock;
  logic          oBlock_valid;
  logic          oBlock_last;
  logic          iBlock_ready;
  logic [0:127]  oLen;
  logic          oLen_valid;
  logic          iLen_ready;
  logic          oBusy;
  logic          oError;

  modport slave (
    input  iStart, iWord, iWord_valid, iWord_type, iWord_last, iWord_bytes,
    input  iAad_ready, iBlock_ready, iLen_ready,
    output oWord_ready, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last,
    output oLen, oLen_valid, oBusy, oError
  );

  modport master (
    output iStart, iWord, iWord_valid, iWord_type, iWord_last, iWord_bytes,
    output iAad_ready, iBlock_ready, iLen_ready,
    input  oWord_ready, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last,
    input  oLen, oLen_valid, oBusy, oError
  );
endinterface

// File: rtl/gcm_input_packer.sv
// rtl/gcm_input_packer.sv - packs AAD/payload words into 128-bit GCM blocks and builds the length block
module gcm_input_packer #(
  parameter int LEN_W = 64
) (
  input logic               iClk,
  input logic               iRst,
  gcm_input_packer_if.slave bus
);
  localparam int CNT_W = LEN_W - 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_AAD     = 3'd1;
  localparam logic [2:0] S_AAD_OUT = 3'd2;
  localparam logic [2:0] S_PT      = 3'd3;
  localparam logic [2:0] S_PT_OUT  = 3'd4;
  localparam logic [2:0] S_LEN_OUT = 3'd5;

  logic [2:0]       state;
  logic [0:127]     pack;
  logic [1:0]       idx;
  logic [CNT_W-1:0] aad_cnt;
  logic [CNT_W-1:0] pt_cnt;
  logic             out_last;
  logic             error_q;

  logic             collect;
  logic             in_pt;
  logic             accept;
  logic             bad_type;
  logic             bad_bytes;
  logic             empty_sec;
  logic [0:31]      word_masked;
  logic [2:0]       word_add;
  logic [CNT_W-1:0] word_add_ext;

  assign collect      = (state == S_AAD) || (state == S_PT);
  assign in_pt        = (state == S_PT);
  assign accept       = bus.iWord_valid && collect;
  assign bad_type     = (bus.iWord_type != in_pt);
  assign bad_bytes    = bus.iWord_last &&
                        ((bus.iWord_bytes > 3'd4) || ((bus.iWord_bytes == 3'd0) && (idx != 2'd0)));
  assign empty_sec    = bus.iWord_last && (bus.iWord_bytes == 3'd0) && (idx == 2'd0);
  assign word_add     = bus.iWord_last ? bus.iWord_bytes : 3'd4;
  assign word_add_ext = {{(CNT_W-3){1'b0}}, word_add};

  // Trailing bytes of a section's last word are forced to zero.
  always_comb begin
    word_masked = bus.iWord;
    for (int b = 0; b < 4; b++) begin
      if (bus.iWord_last && (bus.iWord_bytes <= 3'(b))) begin
        word_masked[8*b +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= S_IDLE;
      pack     <= '0;
      idx      <= '0;
      aad_cnt  <= '0;
      pt_cnt   <= '0;
      out_last <= 1'b0;
      error_q  <= 1'b0;
    end else if (bus.iStart) begin
      state    <= S_AAD;
      pack     <= '0;
      idx      <= '0;
      aad_cnt  <= '0;
      pt_cnt   <= '0;
      out_last <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        S_AAD, S_PT: begin
          if (accept) begin
            if (bad_type || bad_bytes) begin
              error_q <= 1'b1;
              state   <= S_IDLE;
            end else if (empty_sec) begin
              state <= in_pt ? S_LEN_OUT : S_PT;
            end else begin
              pack[{idx, 5'b00000} +: 32] <= word_masked;
              if (in_pt) pt_cnt  <= pt_cnt + word_add_ext;
              else       aad_cnt <= aad_cnt + word_add_ext;
              if (bus.iWord_last || (idx == 2'd3)) begin
                state    <= in_pt ? S_PT_OUT : S_AAD_OUT;
                out_last <= bus.iWord_last;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end
        end
        S_AAD_OUT: begin
          if (bus.iAad_ready) begin
            pack  <= '0;
            idx   <= '0;
            state <= out_last ? S_PT : S_AAD;
          end
        end
        S_PT_OUT: begin
          if (bus.iBlock_ready) begin
            pack  <= '0;
            idx   <= '0;
            state <= out_last ? S_LEN_OUT : S_PT;
          end
        end
        S_LEN_OUT: begin
          if (bus.iLen_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.oWord_ready  = collect;
  assign bus.oAad_valid   = (state == S_AAD_OUT);
  assign bus.oAad_last    = (state == S_AAD_OUT) && out_last;
  assign bus.oAad         = (state == S_AAD_OUT) ? pack : '0;
  assign bus.oBlock_valid = (state == S_PT_OUT);
  assign bus.oBlock_last  = (state == S_PT_OUT) && out_last;
  assign bus.oBlock       = (state == S_PT_OUT) ? pack : '0;
  assign bus.oLen_valid   = (state == S_LEN_OUT);
  assign bus.oLen         = (state == S_LEN_OUT) ? {aad_cnt, 3'b000, pt_cnt, 3'b000} : '0;
  assign bus.oBusy        = (state != S_IDLE);
  assign bus.oError       = error_q;
endmodule

// File: tb/tb_gcm_input_packer.sv
// tb/tb_gcm_input_packer.sv - directed self-checking bench for gcm_input_packer
module tb_gcm_input_packer;
  logic clk;
  logic rst;

  gcm_input_packer_if bus ();

  gcm_input_packer #(.LEN_W(64)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [127:0] aad_q[$];
  logic         aad_last_q[$];
  logic [127:0] blk_q[$];
  logic         blk_last_q[$];
  logic [127:0] len_q[$];
  int           aad_valid_seen = 0;

  int a0, b0, l0, v0;

  // Records every handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (bus.oAad_valid) aad_valid_seen++;
    if (bus.oAad_valid && bus.iAad_ready) begin
      aad_q.push_back(bus.oAad);
      aad_last_q.push_back(bus.oAad_last);
    end
    if (bus.oBlock_valid && bus.iBlock_ready) begin
      blk_q.push_back(bus.oBlock);
      blk_last_q.push_back(bus.oBlock_last);
    end
    if (bus.oLen_valid && bus.iLen_ready) len_q.push_back(bus.oLen);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic snap();
    a0 = aad_q.size();
    b0 = blk_q.size();
    l0 = len_q.size();
    v0 = aad_valid_seen;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic t, input logic l, input logic [2:0] nb);
    int n;
    n = 0;
    bus.iWord       = w;
    bus.iWord_type  = t;
    bus.iWord_last  = l;
    bus.iWord_bytes = nb;
    bus.iWord_valid = 1'b1;
    while (!bus.oWord_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("word_ready_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    bus.iWord_valid = 1'b0;
    bus.iWord_last  = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] base, input int n, input logic t,
                          input logic [2:0] lb, input logic is_last);
    logic [7:0]  b;
    logic        l;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(4 * i);
      l = is_last && (i == n - 1);
      send_word({b, b + 8'd1, b + 8'd2, b + 8'd3}, t, l, l ? lb : 3'd4);
    end
  endtask

  task automatic wait_len();
    int n;
    n = 0;
    while (len_q.size() == l0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("len_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    rst              = 1'b1;
    bus.iStart       = 1'b0;
    bus.iWord        = '0;
    bus.iWord_valid  = 1'b0;
    bus.iWord_type   = 1'b0;
    bus.iWord_last   = 1'b0;
    bus.iWord_bytes  = 3'd0;
    bus.iAad_ready   = 1'b1;
    bus.iBlock_ready = 1'b1;
    bus.iLen_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word_ready", 128'(bus.oWord_ready), 128'(0));
    check("rst_aad_valid",  128'(bus.oAad_valid), 128'(0));
    check("rst_blk_valid",  128'(bus.oBlock_valid), 128'(0));
    check("rst_len_valid",  128'(bus.oLen_valid), 128'(0));
    check("rst_lasts",      128'({bus.oAad_last, bus.oBlock_last}), 128'(0));
    check("rst_busy",       128'(bus.oBusy), 128'(0));
    check("rst_error",      128'(bus.oError), 128'(0));
    check("rst_data",       128'(bus.oAad | bus.oBlock | bus.oLen), 128'(0));
    rst = 1'b0;

    // Basic message: 20-byte AAD, 16-byte PT
    snap();
    pulse_start();
    check("start_busy", 128'(bus.oBusy), 128'(1));
    send_run(8'h00, 4, 1'b0, 3'd4, 1'b0);
    check("latency_aad_valid", 128'(bus.oAad_valid), 128'(1));
    check("latency_ready_low", 128'(bus.oWord_ready), 128'(0));
    send_run(8'h10, 1, 1'b0, 3'd4, 1'b1);
    send_run(8'hF0, 4, 1'b1, 3'd4, 1'b1);
    wait_len();
    check("basic_aad_cnt", 128'(aad_q.size() - a0), 128'(2));
    if (aad_q.size() - a0 >= 2) begin
      check("basic_aad0", aad_q[a0], 128'h000102030405060708090A0B0C0D0E0F);
      check("basic_aad0_last", 128'(aad_last_q[a0]), 128'(0));
      check("basic_aad1", aad_q[a0+1], 128'h10111213000000000000000000000000);
      check("basic_aad1_last", 128'(aad_last_q[a0+1]), 128'(1));
    end
    check("basic_blk_cnt", 128'(blk_q.size() - b0), 128'(1));
    if (blk_q.size() > b0) begin
      check("basic_blk", blk_q[b0], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
      check("basic_blk_last", 128'(blk_last_q[b0]), 128'(1));
    end
    if (len_q.size() > l0) check("basic_len", len_q[l0], 128'h00000000000000A00000000000000080);
    check("basic_idle", 128'(bus.oBusy), 128'(0));

    // Empty AAD, one-byte payload
    snap();
    pulse_start();
    send_word(32'h00000000, 1'b0, 1'b1, 3'd0);
    send_word(32'hAB000000, 1'b1, 1'b1, 3'd1);
    wait_len();
    check("empty_no_aad", 128'(aad_valid_seen - v0), 128'(0));
    check("empty_blk_cnt", 128'(blk_q.size() - b0), 128'(1));
    if (blk_q.size() > b0) begin
      check("empty_blk", blk_q[b0], 128'hAB000000000000000000000000000000);
      check("empty_blk_last", 128'(blk_last_q[b0]), 128'(1));
    end
    if (len_q.size() > l0) check("empty_len", len_q[l0], 128'h00000000000000000000000000000008);

    // Backpressure on the payload channel
    snap();
    pulse_start();
    bus.iBlock_ready = 1'b0;
    send_word(32'h00000000, 1'b0, 1'b1, 3'd0);
    send_run(8'h20, 4, 1'b1, 3'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 128'(bus.oBlock_valid), 128'(1));
      check("bp_data", bus.oBlock, 128'h202122232425262728292A2B2C2D2E2F);
      check("bp_ready_low", 128'(bus.oWord_ready), 128'(0));
      @(posedge clk); #1;
    end
    bus.iBlock_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_hs", 128'(bus.oWord_ready), 128'(1));
    send_word(32'h30313233, 1'b1, 1'b1, 3'd2);
    wait_len();
    check("bp_blk_cnt", 128'(blk_q.size() - b0), 128'(2));
    if (blk_q.size() - b0 >= 2) begin
      check("bp_blk0_last", 128'(blk_last_q[b0]), 128'(0));
      check("bp_blk1", blk_q[b0+1], 128'h30310000000000000000000000000000);
      check("bp_blk1_last", 128'(blk_last_q[b0+1]), 128'(1));
    end
    if (len_q.size() > l0) check("bp_len", len_q[l0], 128'h00000000000000000000000000000090);

    // Order error: payload word in the AAD section at idx 2
    pulse_start();
    send_run(8'h60, 2, 1'b0, 3'd4, 1'b0);
    send_word(32'hDEADBEEF, 1'b1, 1'b0, 3'd4);
    check("err_flag", 128'(bus.oError), 128'(1));
    check("err_busy", 128'(bus.oBusy), 128'(0));
    check("err_ready", 128'(bus.oWord_ready), 128'(0));
    check("err_valids", 128'({bus.oAad_valid, bus.oBlock_valid, bus.oLen_valid}), 128'(0));
    pulse_start();
    check("err_cleared", 128'(bus.oError), 128'(0));
    check("err_restart_busy", 128'(bus.oBusy), 128'(1));

    // Abort by iStart while a payload block is pending
    bus.iBlock_ready = 1'b0;
    send_word(32'h00000000, 1'b0, 1'b1, 3'd0);
    send_run(8'h70, 4, 1'b1, 3'd4, 1'b0);
    check("abort_pending", 128'(bus.oBlock_valid), 128'(1));
    pulse_start();
    check("abort_valid_drop", 128'(bus.oBlock_valid), 128'(0));
    check("abort_ready", 128'(bus.oWord_ready), 128'(1));
    bus.iBlock_ready = 1'b1;
    snap();
    send_run(8'h40, 4, 1'b0, 3'd4, 1'b1);
    send_run(8'h50, 4, 1'b1, 3'd4, 1'b1);
    wait_len();
    if (len_q.size() > l0) check("abort_len", len_q[l0], 128'h00000000000000800000000000000080);

    // Reset while the length block is waiting
    snap();
    bus.iLen_ready = 1'b0;
    pulse_start();
    send_run(8'h90, 1, 1'b0, 3'd4, 1'b1);
    send_word(32'h00000000, 1'b1, 1'b1, 3'd0);
    check("rstmid_len_valid", 128'(bus.oLen_valid), 128'(1));
    check("rstmid_len", bus.oLen, 128'h00000000000000200000000000000000);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_len_valid0", 128'(bus.oLen_valid), 128'(0));
    check("rstmid_len0", bus.oLen, 128'(0));
    check("rstmid_busy", 128'(bus.oBusy), 128'(0));
    check("rstmid_ready", 128'(bus.oWord_ready), 128'(0));
    check("rstmid_other", 128'({bus.oAad_valid, bus.oBlock_valid, bus.oError}), 128'(0));
    rst = 1'b0;
    bus.iLen_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rstmid_no_len_hs", 128'(len_q.size() - l0), 128'(0));
    check("rstmid_still_idle", 128'(bus.oLen_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
